// File: rtl/vc_input_port_credit.sv
// NoC router input port with credit-based flow control: per-VC flit FIFOs,
// per-VC packet FSM feeding VC/switch allocation, registered crossbar stage.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// ST_IDLE   | waiting for a head flit at the FIFO front; stray body flits discarded
// ST_VA     | route latched, requesting a downstream VC from the VC allocator
// ST_ACTIVE | downstream VC held, requesting the switch while flits are buffered
module vc_input_port_credit #(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_W      = 32,
  parameter int OUT_PORT_W  = 3,
  localparam int VCW        = $clog2(VC_NUM),
  localparam int CW         = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_flit_i,
  input  logic [FLIT_W-1:0]            flit_data_i,
  input  logic                         flit_head_i,
  input  logic                         flit_tail_i,
  input  logic [VCW-1:0]               flit_vc_i,
  input  logic [OUT_PORT_W-1:0]        route_i,
  input  logic [VC_NUM-1:0]            va_valid_i,
  input  logic [VC_NUM*VCW-1:0]        va_new_vc_i,
  input  logic                         sa_valid_i,
  input  logic [VCW-1:0]               sa_sel_vc_i,
  output logic [VC_NUM-1:0]            va_request_o,
  output logic [VC_NUM-1:0]            sa_request_o,
  output logic [VC_NUM*OUT_PORT_W-1:0] out_port_o,
  output logic [VC_NUM*VCW-1:0]        downstream_vc_o,
  output logic                         xb_valid_o,
  output logic                         xb_head_o,
  output logic                         xb_tail_o,
  output logic [FLIT_W-1:0]            xb_data_o,
  output logic [VCW-1:0]               xb_vc_o,
  output logic                         credit_o,
  output logic [VCW-1:0]               credit_vc_o,
  output logic [VC_NUM*CW-1:0]         occupancy_o,
  output logic [VC_NUM-1:0]            error_o
);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VA     = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUFFER_SIZE - 1);

  logic [FLIT_W-1:0]     mem_data  [VC_NUM][BUFFER_SIZE];
  logic                  mem_head  [VC_NUM][BUFFER_SIZE];
  logic                  mem_tail  [VC_NUM][BUFFER_SIZE];
  logic [OUT_PORT_W-1:0] mem_route [VC_NUM][BUFFER_SIZE];

  logic [PW-1:0]         wr_ptr  [VC_NUM];
  logic [PW-1:0]         rd_ptr  [VC_NUM];
  logic [CW-1:0]         count   [VC_NUM];
  logic [1:0]            state   [VC_NUM];
  logic [OUT_PORT_W-1:0] route_q [VC_NUM];
  logic [VCW-1:0]        dvc_q   [VC_NUM];

  logic [FLIT_W-1:0]     front_data  [VC_NUM];
  logic [OUT_PORT_W-1:0] front_route [VC_NUM];
  logic [VC_NUM-1:0]     front_head, front_tail, non_empty;
  logic [VC_NUM-1:0]     wr_en, drop, grant_ok, grant_err, disc_pop, pop;

  logic [FLIT_W-1:0]     sel_data;
  logic                  sel_head, sel_tail;
  logic [VCW-1:0]        sel_dvc, pop_vc;

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      front_data[v]  = mem_data[v][rd_ptr[v]];
      front_route[v] = mem_route[v][rd_ptr[v]];
      front_head[v]  = mem_head[v][rd_ptr[v]];
      front_tail[v]  = mem_tail[v][rd_ptr[v]];
      non_empty[v]   = (count[v] != '0);
      wr_en[v]       = valid_flit_i && (flit_vc_i == VCW'(v)) && (count[v] != FULL_CNT);
      drop[v]        = valid_flit_i && (flit_vc_i == VCW'(v)) && (count[v] == FULL_CNT);
      grant_ok[v]    = sa_valid_i && (sa_sel_vc_i == VCW'(v)) &&
                       (state[v] == ST_ACTIVE) && non_empty[v];
      grant_err[v]   = sa_valid_i && (sa_sel_vc_i == VCW'(v)) &&
                       !((state[v] == ST_ACTIVE) && non_empty[v]);
    end
  end

  // Only one credit can leave per cycle, so a stray body flit is discarded
  // only when no switch grant pops this cycle, lowest VC first; others retry.
  always_comb begin
    logic taken;
    taken    = |grant_ok;
    disc_pop = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if ((state[v] == ST_IDLE) && non_empty[v] && !front_head[v] && !taken) begin
        disc_pop[v] = 1'b1;
        taken       = 1'b1;
      end
    end
  end

  assign pop = grant_ok | disc_pop;

  always_comb begin
    sel_data = '0;
    sel_head = 1'b0;
    sel_tail = 1'b0;
    sel_dvc  = '0;
    pop_vc   = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (grant_ok[v]) begin
        sel_data = front_data[v];
        sel_head = front_head[v];
        sel_tail = front_tail[v];
        sel_dvc  = dvc_q[v];
      end
      if (pop[v]) pop_vc = VCW'(v);
    end
  end

  always_comb begin
    va_request_o    = '0;
    sa_request_o    = '0;
    out_port_o      = '0;
    downstream_vc_o = '0;
    occupancy_o     = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      va_request_o[v] = (state[v] == ST_VA);
      sa_request_o[v] = (state[v] == ST_ACTIVE) && non_empty[v];
      out_port_o[v*OUT_PORT_W +: OUT_PORT_W] = route_q[v];
      downstream_vc_o[v*VCW +: VCW]          = dvc_q[v];
      occupancy_o[v*CW +: CW]                = count[v];
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (wr_en[v]) begin
        mem_data[v][wr_ptr[v]]  <= flit_data_i;
        mem_head[v][wr_ptr[v]]  <= flit_head_i;
        mem_tail[v][wr_ptr[v]]  <= flit_tail_i;
        mem_route[v][wr_ptr[v]] <= route_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v]  <= '0;
        rd_ptr[v]  <= '0;
        count[v]   <= '0;
        state[v]   <= ST_IDLE;
        route_q[v] <= '0;
        dvc_q[v]   <= '0;
      end
      error_o <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (wr_en[v]) wr_ptr[v] <= (wr_ptr[v] == LAST_PTR) ? '0 : wr_ptr[v] + 1'b1;
        if (pop[v])   rd_ptr[v] <= (rd_ptr[v] == LAST_PTR) ? '0 : rd_ptr[v] + 1'b1;
        if (wr_en[v] && !pop[v])      count[v] <= count[v] + 1'b1;
        else if (!wr_en[v] && pop[v]) count[v] <= count[v] - 1'b1;
        if (drop[v] || grant_err[v] || disc_pop[v]) error_o[v] <= 1'b1;
        case (state[v])
          ST_IDLE: begin
            if (non_empty[v] && front_head[v]) begin
              route_q[v] <= front_route[v];
              state[v]   <= ST_VA;
            end
          end
          ST_VA: begin
            if (va_valid_i[v]) begin
              dvc_q[v] <= va_new_vc_i[v*VCW +: VCW];
              state[v] <= ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (grant_ok[v] && front_tail[v]) state[v] <= ST_IDLE;
          end
          default: state[v] <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xb_valid_o  <= 1'b0;
      xb_head_o   <= 1'b0;
      xb_tail_o   <= 1'b0;
      xb_data_o   <= '0;
      xb_vc_o     <= '0;
      credit_o    <= 1'b0;
      credit_vc_o <= '0;
    end else begin
      xb_valid_o <= |grant_ok;
      credit_o   <= |pop;
      if (|grant_ok) begin
        xb_data_o <= sel_data;
        xb_head_o <= sel_head;
        xb_tail_o <= sel_tail;
        xb_vc_o   <= sel_dvc;
      end
      if (|pop) credit_vc_o <= pop_vc;
    end
  end

endmodule

// File: doc/vc_input_port_credit.md
# vc_input_port_credit

Parametrised input port for the NoC router: one per router input, replacing the on/off-signalled port with credit-based flow control. Holds VC_NUM per-VC flit FIFOs of depth BUFFER_SIZE and runs a per-VC packet state machine (IDLE/VA/ACTIVE) that drives VC-allocator and switch-allocator requests. Drives the crossbar from a registered output stage and returns one credit per flit leaving a buffer. Reports per-VC occupancy and sticky protocol errors.

## Interface
- VC_NUM, 2, virtual channels per port (≥2); VCW = $clog2(VC_NUM)
- BUFFER_SIZE, 8, flits per VC FIFO (≥2, any integer); CW = $clog2(BUFFER_SIZE+1)
- FLIT_W, 32, payload bits per flit
- OUT_PORT_W, 3, width of output-port (route) code

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_flit_i  in  1  flit present on inputs this cycle
- flit_data_i  in  FLIT_W  payload
- flit_head_i / flit_tail_i  in  1 each  head / tail markers (both set = single-flit packet)
- flit_vc_i  in  VCW  target VC of incoming flit
- route_i  in  OUT_PORT_W  output port for incoming head flit; stored with the flit, ignored for non-head
- va_valid_i  in  VC_NUM  VA grant per VC
- va_new_vc_i  in  VC_NUM*VCW  downstream VC per grant (slice v)
- sa_valid_i  in  1  SA grant this cycle
- sa_sel_vc_i  in  VCW  VC granted by SA
- va_request_o  out  VC_NUM  VC in VA state
- sa_request_o  out  VC_NUM  VC ACTIVE and non-empty
- out_port_o  out  VC_NUM*OUT_PORT_W  latched route per VC
- downstream_vc_o  out  VC_NUM*VCW  latched downstream VC per VC
- xb_valid_o, xb_head_o, xb_tail_o  out  1 each  registered crossbar flit strobe/markers
- xb_data_o  out  FLIT_W  registered payload; xb_vc_o out VCW downstream VC of that flit
- credit_o  out  1  one-cycle credit pulse to upstream; credit_vc_o out VCW its VC
- occupancy_o  out  VC_NUM*CW  flits held per VC
- error_o  out  VC_NUM  sticky error per VC

## Operation
- Write: valid_flit_i with count[v]<BUFFER_SIZE stores {data, head, tail, route} at wr_ptr[v]. If count[v]==BUFFER_SIZE the flit is dropped and error_o[v] set; a same-cycle pop does not rescue it (fullness uses registered count).
- Pointers wrap BUFFER_SIZE-1 → 0. count[v] +1 on write, −1 on pop, unchanged on both.
- Per-VC FSM:
  - IDLE: front valid and head → latch front route into out_port_o[v], go VA. Front valid and not head → error_o[v] set, flit popped (discarded, credit returned), stay IDLE.
  - VA: va_request_o[v]=1. On va_valid_i[v] latch va_new_vc_i slice into downstream_vc_o[v], go ACTIVE. va_valid_i[v] in any other state ignored.
  - ACTIVE: sa_request_o[v]=!empty. Grant (sa_valid_i, sa_sel_vc_i==v, non-empty) pops front into output register; popped tail → IDLE next cycle, else stay.
- Grant to empty VC or VC not ACTIVE: no pop, no xb_valid_o, error_o[v] set.
- out_port_o/downstream_vc_o hold value until next latch; undefined-use outside VA/ACTIVE but never glitch.
- Reset: all FSMs IDLE, pointers/counts 0, error_o, xb_*, credit_o, latched route/VC all 0. Reset mid-packet discards buffered flits without credit return; upstream resets concurrently.

## Timing
- Write at edge N; flit at FIFO front and counted in occupancy_o from cycle N+1.
- IDLE→VA at edge after head reaches front; va_request_o combinational from state.
- va_valid_i in cycle M → ACTIVE from M+1; sa_request_o valid from M+1.
- Grant in cycle G → xb_* and credit_o/credit_vc_o asserted during G+1, one cycle, VC = source VC for credit, downstream VC for xb_vc_o.
- Minimum latency head write (cycle 0) → xb_valid_o: cycle 4 with immediate grants. Back-to-back grants sustain one flit/cycle.
- Discard pop in IDLE: credit_o pulses next cycle, xb_valid_o stays 0.

## Test plan
- Reset: drive rst=0 mid-traffic → all outputs 0, occupancy 0, next head packet processed normally.
- Single 3-flit packet VC1, route 2, VA grant vc 0, SA grants every cycle → xb_valid_o cycles 4,5,6, xb_vc_o=0, credit_vc_o=1 each, VC1 IDLE after tail.
- Fill VC0 with BUFFER_SIZE flits, write one more → dropped, error_o[0]=1, occupancy_o[0]=BUFFER_SIZE.
- Simultaneous write and pop same VC at count 3 → count stays 3, FIFO order preserved across pointer wrap.
- Body flit into IDLE VC → discarded, credit_o pulse, error_o set, no xb_valid_o.
- Two VCs interleaved under SA round-robin, single-flit packets → each flit output once, VC IDLE after each.
